// File: rtl/seven_segment_reader.sv
// seven_segment_reader
//
// Passive receiver for a multiplexed four-digit seven-segment display bus.
// It samples the bus and rebuilds the displayed 16-bit hex number and the
// four decimal points. Every complete, consistent frame is reported with a
// one-cycle valid pulse.
//
// Parameters:
//   settle_cycles    - identical samples needed before a digit is captured (2..255)
//   seg_active_low   - 1: segment/dot lines are lit when 0
//   anode_active_low - 1: an anode line is selected when 0
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   abcdefgh - segment bus, [7]=a .. [1]=g, [0]=dot
//   digit    - anode bus, bit i selects digit i
//   num      - last complete frame, digit i in num[4i+3:4i]
//   dots     - last complete frame, dot of digit i in dots[i]
//   valid    - one-cycle pulse when num/dots update
//   err      - one-cycle pulse when a settled digit has an undecodable pattern
module seven_segment_reader #(
  parameter int unsigned settle_cycles    = 4,
  parameter bit          seg_active_low   = 1'b1,
  parameter bit          anode_active_low = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  abcdefgh,
  input  logic [3:0]  digit,
  output logic [15:0] num,
  output logic [3:0]  dots,
  output logic        valid,
  output logic        err
);

  localparam logic [7:0] SETTLE_TARGET = 8'(settle_cycles);

  typedef enum logic [1:0] {BLANK, SETTLE, HELD} state_t;

  state_t      state;
  logic [7:0]  seg_s1, seg_s2;
  logic [3:0]  an_s1, an_s2;
  logic [11:0] sample_q;
  logic [7:0]  count;
  logic [15:0] shadow_num;
  logic [3:0]  shadow_dots;
  logic [3:0]  seen;

  logic [7:0]  seg_norm;
  logic [3:0]  an_norm;
  logic [11:0] sample;
  logic        selected;
  logic        same;
  logic [1:0]  idx;
  logic [4:0]  dec;
  logic [8:0]  count_inc;
  logic        do_capture;
  logic        cap_ok;
  logic        cap_bad;
  logic [15:0] shadow_num_nxt;
  logic [3:0]  shadow_dots_nxt;
  logic [3:0]  seen_nxt;
  logic        frame_done;

  // Returns {ok, nibble}; ok is 0 for any pattern outside the hex font.
  function automatic logic [4:0] decode7(input logic [6:0] s);
    case (s)
      7'b1111110: decode7 = 5'h10;
      7'b0110000: decode7 = 5'h11;
      7'b1101101: decode7 = 5'h12;
      7'b1111001: decode7 = 5'h13;
      7'b0110011: decode7 = 5'h14;
      7'b1011011: decode7 = 5'h15;
      7'b1011111: decode7 = 5'h16;
      7'b1110000: decode7 = 5'h17;
      7'b1111111: decode7 = 5'h18;
      7'b1111011: decode7 = 5'h19;
      7'b1110111: decode7 = 5'h1A;
      7'b0011111: decode7 = 5'h1B;
      7'b1001110: decode7 = 5'h1C;
      7'b0111101: decode7 = 5'h1D;
      7'b1001111: decode7 = 5'h1E;
      7'b1000111: decode7 = 5'h1F;
      default:    decode7 = 5'h00;
    endcase
  endfunction

  // Normalise so that 1 always means lit / selected. The anode and segment
  // bits together form the sample whose stability is tracked.
  always_comb begin
    seg_norm  = seg_active_low   ? ~seg_s2 : seg_s2;
    an_norm   = anode_active_low ? ~an_s2  : an_s2;
    sample    = {an_norm, seg_norm};
    selected  = (an_norm != 4'b0000) && ((an_norm & (an_norm - 4'd1)) == 4'b0000);
    same      = (sample == sample_q);
    count_inc = {1'b0, count} + 9'd1;
    dec       = decode7(seg_norm[7:1]);
    case (an_norm)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // A capture fires on the edge where the stable count would reach the target.
  // The frame completes when the capture being made fills the last seen bit,
  // so the copy to num/dots must include that capture.
  always_comb begin
    do_capture      = (state == SETTLE) && selected && same &&
                      (count_inc >= {1'b0, SETTLE_TARGET});
    cap_ok          = do_capture && dec[4];
    cap_bad         = do_capture && !dec[4];
    shadow_num_nxt  = shadow_num;
    shadow_dots_nxt = shadow_dots;
    seen_nxt        = seen;
    if (cap_ok) begin
      shadow_num_nxt[{idx, 2'b00} +: 4] = dec[3:0];
      shadow_dots_nxt[idx]              = seg_norm[0];
      seen_nxt[idx]                     = 1'b1;
    end
    frame_done = cap_ok && (seen_nxt == 4'b1111);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1      <= '0;
      seg_s2      <= '0;
      an_s1       <= '0;
      an_s2       <= '0;
      sample_q    <= '0;
      state       <= BLANK;
      count       <= '0;
      shadow_num  <= '0;
      shadow_dots <= '0;
      seen        <= '0;
      num         <= '0;
      dots        <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
    end else begin
      seg_s1      <= abcdefgh;
      seg_s2      <= seg_s1;
      an_s1       <= digit;
      an_s2       <= an_s1;
      sample_q    <= sample;
      shadow_num  <= shadow_num_nxt;
      shadow_dots <= shadow_dots_nxt;
      seen        <= frame_done ? 4'b0000 : seen_nxt;
      valid       <= frame_done;
      err         <= cap_bad;
      if (frame_done) begin
        num  <= shadow_num_nxt;
        dots <= shadow_dots_nxt;
      end

      case (state)
        BLANK: begin
          if (selected) begin
            state <= SETTLE;
            count <= 8'd1;
          end
        end
        SETTLE: begin
          if (!selected) begin
            state <= BLANK;
          end else if (!same) begin
            count <= 8'd1;
          end else if (do_capture) begin
            state <= HELD;
            count <= SETTLE_TARGET;
          end else begin
            count <= count_inc[7:0];
          end
        end
        HELD: begin
          if (!selected) begin
            state <= BLANK;
          end else if (!same) begin
            state <= SETTLE;
            count <= 8'd1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb_seven_segment_reader
//
// Bench for seven_segment_reader. Two instances: one with the default
// active-low bus, one with both polarities active-high. Expected frames are
// queued when a scan is driven and compared when valid pulses.
module tb_seven_segment_reader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  abcdefgh, abcdefgh_p;
  logic [3:0]  digit, digit_p;
  logic [15:0] num, num_p;
  logic [3:0]  dots, dots_p;
  logic        valid, valid_p;
  logic        err, err_p;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  dots;
  } exp_t;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  dots;
    int          hold;
    int          gap;
  } frame_t;

  exp_t   q[$];
  exp_t   q_p[$];
  frame_t vecs[5];

  int checks      = 0;
  int failures    = 0;
  int valid_count = 0;
  int err_seen    = 0;
  int err_seen_p  = 0;
  int exp_err     = 0;
  int saved_valid;
  bit pol_mode    = 1'b0;

  seven_segment_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .abcdefgh (abcdefgh),
    .digit    (digit),
    .num      (num),
    .dots     (dots),
    .valid    (valid),
    .err      (err)
  );

  seven_segment_reader #(
    .settle_cycles    (4),
    .seg_active_low   (1'b0),
    .anode_active_low (1'b0)
  ) dut_p (
    .clk      (clk),
    .reset_n  (reset_n),
    .abcdefgh (abcdefgh_p),
    .digit    (digit_p),
    .num      (num_p),
    .dots     (dots_p),
    .valid    (valid_p),
    .err      (err_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;
      4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drive one logical (active-high) bus state for a number of cycles on the
  // bus of whichever instance is under test; the other bus is left blank.
  task automatic applyStimulus(input logic [3:0] an, input logic [7:0] seg,
                               input int cycles);
    if (!pol_mode) begin
      abcdefgh   = ~seg;
      digit      = ~an;
      abcdefgh_p = 8'h00;
      digit_p    = 4'h0;
    end else begin
      abcdefgh   = 8'hFF;
      digit      = 4'hF;
      abcdefgh_p = seg;
      digit_p    = an;
    end
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scan(input logic [15:0] val, input logic [3:0] d,
                      input logic [3:0] mask, input int hold, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        applyStimulus(4'(1 << i), {seg7(val[4*i +: 4]), d[i]}, hold);
        applyStimulus(4'h0, 8'h00, gap);
      end
    end
  endtask

  task automatic wait_drain(input string name, input bit pol);
    int n = 0;
    while (((pol ? q_p.size() : q.size()) != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput(name, pol ? q_p.size() : q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      valid_count++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid actual=valid num=%h required=no valid", num);
      end else begin
        e = q.pop_front();
        checkOutput("frame_num", {16'h0, num}, {16'h0, e.num});
        checkOutput("frame_dots", {28'h0, dots}, {28'h0, e.dots});
      end
    end
    if (valid_p) begin
      if (q_p.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid_p actual=valid num=%h required=no valid", num_p);
      end else begin
        e = q_p.pop_front();
        checkOutput("frame_num_p", {16'h0, num_p}, {16'h0, e.num});
        checkOutput("frame_dots_p", {28'h0, dots_p}, {28'h0, e.dots});
      end
    end
    if (err)   err_seen++;
    if (err_p) err_seen_p++;
  end

  initial begin
    vecs[0] = '{16'h1A3F, 4'b0101, 20, 3};
    vecs[1] = '{16'h0000, 4'b1111, 20, 3};
    vecs[2] = '{16'hFFFF, 4'b0000, 20, 0};
    vecs[3] = '{16'h8421, 4'b1010, 4, 1};
    vecs[4] = '{16'hC0DE, 4'b0011, 30, 5};

    reset_n    = 1'b0;
    abcdefgh   = 8'hFF;
    digit      = 4'hF;
    abcdefgh_p = 8'h00;
    digit_p    = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_num", {16'h0, num}, 32'h0);
    checkOutput("reset_dots", {28'h0, dots}, 32'h0);
    checkOutput("reset_valid", {31'h0, valid}, 32'h0);
    checkOutput("reset_err", {31'h0, err}, 32'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table of full scans, including back-to-back digits and exact-settle dwell.
    for (int v = 0; v < 5; v++) begin
      q.push_back('{vecs[v].num, vecs[v].dots});
      scan(vecs[v].num, vecs[v].dots, 4'hF, vecs[v].hold, vecs[v].gap);
      wait_drain($sformatf("table_frame_%0d", v), 1'b0);
      checkOutput($sformatf("table_err_%0d", v), err_seen, exp_err);
    end

    // Dwell one sample short of settle is ignored; exactly settle captures.
    saved_valid = valid_count;
    scan(16'h5678, 4'b1000, 4'b0111, 20, 3);
    applyStimulus(4'b1000, {seg7(4'h5), 1'b1}, 3);
    applyStimulus(4'h0, 8'h00, 20);
    checkOutput("short_dwell_no_valid", valid_count, saved_valid);
    q.push_back('{16'h5678, 4'b1000});
    applyStimulus(4'b1000, {seg7(4'h5), 1'b1}, 4);
    applyStimulus(4'h0, 8'h00, 3);
    wait_drain("exact_dwell_frame", 1'b0);

    // Two-cycle wrong-segment ghosts on the next anode, one of them undecodable.
    q.push_back('{16'h2B7D, 4'b0110});
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'(1 << i), {seg7(4'(16'h2B7D >> (4*i))), i == 1 || i == 2}, 20);
      if (i == 0)
        applyStimulus(4'(1 << (i+1)), 8'b10101010, 2);
      else
        applyStimulus(4'(1 << (i+1)), {seg7(4'(16'h2B7D >> (4*(i+1))) ^ 4'h3), 1'b1}, 2);
      applyStimulus(4'h0, 8'h00, 3);
    end
    applyStimulus(4'b1000, {seg7(4'h2), 1'b0}, 20);
    applyStimulus(4'h0, 8'h00, 3);
    wait_drain("glitch_frame", 1'b0);
    checkOutput("glitch_err", err_seen, exp_err);

    // Undecodable digit 2 held long: exactly one err, no frame until fixed.
    saved_valid = valid_count;
    scan(16'h9E40, 4'b0000, 4'b1011, 20, 3);
    exp_err++;
    applyStimulus(4'b0100, 8'b10101010, 300);
    applyStimulus(4'h0, 8'h00, 10);
    checkOutput("invalid_err_count", err_seen, exp_err);
    checkOutput("invalid_no_valid", valid_count, saved_valid);
    q.push_back('{16'h9E40, 4'b0000});
    applyStimulus(4'b0100, {seg7(4'hE), 1'b0}, 20);
    applyStimulus(4'h0, 8'h00, 3);
    wait_drain("invalid_fixed_frame", 1'b0);

    // Two anodes at once, then everything off.
    saved_valid = valid_count;
    applyStimulus(4'b0101, {seg7(4'h8), 1'b1}, 30);
    applyStimulus(4'h0, 8'h00, 30);
    checkOutput("multi_anode_no_valid", valid_count, saved_valid);
    checkOutput("multi_anode_err", err_seen, exp_err);

    // Reset in the middle of a frame discards partial captures.
    scan(16'h3333, 4'b0111, 4'b0111, 20, 3);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset_num", {16'h0, num}, 32'h0);
    checkOutput("midreset_dots", {28'h0, dots}, 32'h0);
    checkOutput("midreset_valid", {31'h0, valid}, 32'h0);
    checkOutput("midreset_err", {31'h0, err}, 32'h0);
    reset_n = 1'b1;
    saved_valid = valid_count;
    scan(16'h7000, 4'b1000, 4'b1000, 20, 20);
    checkOutput("after_reset_no_valid", valid_count, saved_valid);
    q.push_back('{16'h7CBA, 4'b1001});
    scan(16'h7CBA, 4'b1001, 4'b0111, 20, 3);
    wait_drain("after_reset_frame", 1'b0);

    // Active-high bus on the second instance.
    pol_mode = 1'b1;
    saved_valid = valid_count;
    q_p.push_back('{16'hBEEF, 4'b1001});
    scan(16'hBEEF, 4'b1001, 4'hF, 20, 3);
    wait_drain("polarity_frame", 1'b1);
    checkOutput("polarity_err", err_seen_p, 0);
    checkOutput("polarity_main_idle", valid_count, saved_valid);

    checkOutput("final_err", err_seen, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Passive receiver for the multiplexed four-digit seven-segment bus (`abcdefgh`, `digit`) that the board display driver produces. It samples the bus and reconstructs the displayed 16-bit hexadecimal number and the four decimal-point bits. It reports each complete, consistent frame with a one-cycle valid pulse. It is used for loopback self-test on the board and as a bus checker in the display testbenches.

## Interface
- `settle_cycles`, default 4: consecutive identical synchronized samples required before a digit is captured; legal range 2..255.
- `seg_active_low`, default 1: 1 means segment and dot lines are lit when 0.
- `anode_active_low`, default 1: 1 means an anode line is selected when 0.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `abcdefgh` input, 8 bits: segment bus; [7]=a … [1]=g, [0]=dot.
- `digit` input, 4 bits: anode bus; bit i selects digit i.
- `num` output, 16 bits: last complete frame; digit i maps to `num[4i+3:4i]`.
- `dots` output, 4 bits: last complete frame; dot of digit i maps to `dots[i]`.
- `valid` output, 1 bit: one-cycle pulse when `num`/`dots` update.
- `err` output, 1 bit: one-cycle pulse when a settled digit carries an undecodable segment pattern.

## Operation
- Input conditioning:
  - `abcdefgh` and `digit` pass through a 2-flop synchronizer.
  - After synchronizing, polarity is normalized so that 1 means lit / selected.
- Selection:
  - A sample is "selected" when exactly one normalized anode bit is 1.
  - Zero or more than one active anode counts as blanking.
- State machine, states BLANK, SETTLE, HELD:
  - BLANK: sample not selected. A selected sample moves to SETTLE with the stability count set to 1.
  - SETTLE: if the sample equals the previous sample, the count increments. If it differs but is still selected, the count restarts at 1. If it is not selected, go to BLANK. When the count reaches `settle_cycles`, perform the capture and go to HELD.
  - HELD: stay while the sample is unchanged; no re-capture. A change to a different selected sample goes to SETTLE with count 1. A non-selected sample goes to BLANK.
- Capture decode, using segments a..g with a as the MSB:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Capture results:
  - Valid pattern: store the nibble and dot into shadow slot i and set `seen[i]`.
  - Any other pattern: pulse `err`. The slot and `seen[i]` are unchanged.
  - Re-capturing an already-seen digit overwrites its shadow slot.
- Frame completion:
  - The frame completes on the edge where `seen` becomes 4'b1111.
  - On that edge, the complete shadow (including the capture made on that edge) is copied to `num`/`dots`, `valid` pulses, and `seen` clears to 0.
- `err` and `valid` can never coincide, because an invalid capture does not set `seen`.

## Timing
- Reset values while `reset_n`=0:
  - `num`=16'h0000, `dots`=4'b0000, `valid`=0, `err`=0.
  - Shadow and `seen` are 0, the state is BLANK, and the synchronizers are cleared.
- Reset deassertion mid-frame: all partial captures are discarded; the first frame reported afterwards needs four fresh captures.
- Latency: a digit applied stable from cycle T is captured on the edge ending cycle T+1+`settle_cycles`. That is 2 synchronizer cycles plus `settle_cycles` samples.
- `valid` and `err` are registered pulses, high for exactly one cycle per event.
- `num`/`dots` hold their value between frames.
- The stability counter is 8 bits and saturates at `settle_cycles`, so a long dwell never wraps or re-captures.
- Any digit dwell shorter than `settle_cycles` samples is ignored, which filters anode-switching ghosts.
- Digit order is irrelevant; frames complete in any scan order.

## Test plan
- Defaults, active-low bus:
  - Stimulus: scan 16'h1A3F with dots 4'b0101, each digit held 20 cycles with 3 blank cycles between digits.
  - Required response: one `valid` pulse per full scan, `num`=16'h1A3F, `dots`=4'b0101, `err`=0.
- Glitch filter:
  - Stimulus: between real digits, insert a 2-cycle wrong-segment sample on the next anode.
  - Required response: no capture of the glitch, `num` unchanged from the real value, no `err`.
- Invalid pattern:
  - Stimulus: digit 2 shows 1010101 for 20 cycles.
  - Required response: exactly one `err` pulse; no `valid` until digit 2 is later shown validly; the eventual frame contains that later value.
- Multi-anode and blank:
  - Stimulus: `digit` with two bits active for 30 cycles, then all anodes off for 30 cycles.
  - Required response: no captures, no `valid`, no `err`.
- Reset mid-frame:
  - Stimulus: capture digits 0–2, pulse `reset_n` low, then show only digit 3.
  - Required response: outputs are 0 after reset; no `valid` until all four digits are re-captured.
- Polarity:
  - Stimulus: set `seg_active_low`=0 and `anode_active_low`=0, then scan 16'hBEEF.
  - Required response: `valid` with `num`=16'hBEEF.
